regfile_bist: RTL and testbench



---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_bist_if.sv | 15 +
 rtl/regfile_bist_checker.sv | 74 +++++++
 rtl/regfile_bist.sv | 134 +++++++++++++
 tb/tb_regfile_bist.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, BIST state encoding and the per-register test pattern
// used by the register-file self-test engine.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 31;
  localparam int FAIL_W     = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  function automatic logic [DATA_W-1:0] pattern(input logic [REG_ADDR_W-1:0] idx,
                                                input logic                  phase);
    logic [DATA_W-1:0] z;
    z = DATA_W'(idx);
    return phase ? ~z : z;
  endfunction

  // The hard-wired zero register reads 0 whatever was written to it.
  function automatic logic [DATA_W-1:0] expected(input logic [REG_ADDR_W-1:0] idx,
                                                 input logic                  phase);
    return (idx == REG_ADDR_W'(ZERO_REG)) ? '0 : pattern(idx, phase);
  endfunction
endpackage

// File: rtl/regfile_bist_if.sv
// Write/read port bundle between the BIST engine (master) and the register file.
interface regfile_bist_if;
  import regfile_pkg::*;

  logic [REG_ADDR_W-1:0] ra;
  logic [REG_ADDR_W-1:0] rb;
  logic [REG_ADDR_W-1:0] rw;
  logic [DATA_W-1:0]     bus_w;
  logic                  reg_wr;
  logic [DATA_W-1:0]     bus_a;
  logic [DATA_W-1:0]     bus_b;

  modport master (output ra, rb, rw, bus_w, reg_wr, input bus_a, bus_b);
  modport slave  (input ra, rb, rw, bus_w, reg_wr, output bus_a, bus_b);
endinterface

// File: rtl/regfile_bist_checker.sv
// Captures each launched read pair with its data one cycle after launch,
// compares it in the following cycle and accumulates the failure summary.
module regfile_bist_checker
  import regfile_pkg::*;
(
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  launch,
  input  logic                  phase,
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] rb,
  input  logic [DATA_W-1:0]     bus_a,
  input  logic [DATA_W-1:0]     bus_b,
  output logic [FAIL_W-1:0]     fail_count,
  output logic [FAIL_W-1:0]     fail_count_next,
  output logic [REG_ADDR_W-1:0] first_fail_addr
);
  logic                  vld_q, vld_d;
  logic                  phase_q, phase_d;
  logic [REG_ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0]     data_a_q, data_a_d, data_b_q, data_b_d;
  logic [FAIL_W-1:0]     fail_count_q, fail_count_d;
  logic [REG_ADDR_W-1:0] first_fail_q, first_fail_d;
  logic                  mis_a, mis_b;

  always_comb begin
    vld_d        = launch;
    phase_d      = phase;
    addr_a_d     = ra;
    addr_b_d     = rb;
    data_a_d     = bus_a;
    data_b_d     = bus_b;
    mis_a        = vld_q && (data_a_q != expected(addr_a_q, phase_q));
    mis_b        = vld_q && (data_b_q != expected(addr_b_q, phase_q));
    fail_count_d = fail_count_q + FAIL_W'(mis_a) + FAIL_W'(mis_b);
    first_fail_d = first_fail_q;
    // Only the first failing pair of a run is recorded; A wins a tie.
    if (fail_count_q == '0) begin
      if (mis_a)      first_fail_d = addr_a_q;
      else if (mis_b) first_fail_d = addr_b_q;
    end
    if (clr) begin
      fail_count_d = '0;
      first_fail_d = '0;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      vld_q        <= 1'b0;
      phase_q      <= 1'b0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      fail_count_q <= '0;
      first_fail_q <= '0;
    end else begin
      vld_q        <= vld_d;
      phase_q      <= phase_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign fail_count      = fail_count_q;
  assign fail_count_next = fail_count_d;
  assign first_fail_addr = first_fail_q;
endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST engine: writes a pattern to every register, reads it back
// two per cycle, repeats with the inverted pattern and reports pass/fail.
//   state | meaning
//   IDLE  | ports released to the datapath, waiting for start
//   WRITE | writing pattern(idx, phase) to register idx
//   READ  | launching read pair 2*idx / 2*idx+1
//   DRAIN | comparing the final read pair of the phase
//   DONE  | one-cycle done pulse with pass valid
module regfile_bist
  import regfile_pkg::*;
(
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [FAIL_W-1:0]     fail_count,
  output logic [REG_ADDR_W-1:0] first_fail_addr,
  regfile_bist_if.master        rf
);
  bist_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d;
  logic                  phase_q, phase_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  reg_wr_q, reg_wr_d;
  logic [REG_ADDR_W-1:0] rw_q, rw_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_W-1:0]     bus_w_q, bus_w_d;
  logic [FAIL_W-1:0]     fail_count_next;
  logic                  clr;

  assign clr = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_WRITE;
        idx_d   = '0;
        phase_d = 1'b0;
        pass_d  = 1'b0;
      end
      ST_WRITE: if (idx_q == REG_ADDR_W'(NUM_REGS - 1)) begin
        state_d = ST_READ;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      ST_READ: if (idx_q == REG_ADDR_W'(NUM_REGS / 2 - 1)) begin
        state_d = ST_DRAIN;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      ST_DRAIN: if (!phase_q) begin
        state_d = ST_WRITE;
        phase_d = 1'b1;
        idx_d   = '0;
      end else begin
        // The last pair is being compared this cycle, so use the next count.
        state_d = ST_DONE;
        pass_d  = (fail_count_next == '0);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Port drive follows the next state so every output is a plain flop.
    busy_d   = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
    reg_wr_d = (state_d == ST_WRITE);
    rw_d     = reg_wr_d ? idx_d : rw_q;
    bus_w_d  = reg_wr_d ? pattern(idx_d, phase_d) : bus_w_q;
    ra_d     = (state_d == ST_READ) ? {idx_d[REG_ADDR_W-2:0], 1'b0} : ra_q;
    rb_d     = (state_d == ST_READ) ? {idx_d[REG_ADDR_W-2:0], 1'b1} : rb_q;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      phase_q  <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reg_wr_q <= 1'b0;
      rw_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      bus_w_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      reg_wr_q <= reg_wr_d;
      rw_q     <= rw_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      bus_w_q  <= bus_w_d;
    end
  end

  regfile_bist_checker u_checker (
    .clk_sys         (clk_sys),
    .rst             (rst),
    .clr             (clr),
    .launch          (state_q == ST_READ),
    .phase           (phase_q),
    .ra              (ra_q),
    .rb              (rb_q),
    .bus_a           (rf.bus_a),
    .bus_b           (rf.bus_b),
    .fail_count      (fail_count),
    .fail_count_next (fail_count_next),
    .first_fail_addr (first_fail_addr)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign rf.reg_wr = reg_wr_q;
  assign rf.rw     = rw_q;
  assign rf.ra     = ra_q;
  assign rf.rb     = rb_q;
  assign rf.bus_w  = bus_w_q;
endmodule

// File: tb/tb_regfile_bist.sv
// Scoreboard bench for regfile_bist with a behavioural register file that can
// inject stuck bits, a transparent X31 and a forced read bus.
module tb_regfile_bist;
  import regfile_pkg::*;

  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0000_0000;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass;
  logic [6:0] fail_count;
  logic [4:0] first_fail_addr;

  regfile_bist_if rf_if ();

  regfile_bist dut (
    .clk_sys         (clk_sys),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr),
    .rf              (rf_if)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // fault configuration of the behavioural register file
  bit f_dead = 0, f_x31 = 0, f_stuck = 0, f_sval = 0;
  int f_sreg = 0, f_sbit = 0;

  logic [63:0] mem [32];
  logic [63:0] wtmp;
  always @(negedge clk_sys) begin
    if (rf_if.reg_wr) begin
      wtmp = rf_if.bus_w;
      if (f_stuck && (int'(rf_if.rw) == f_sreg)) wtmp[f_sbit] = f_sval;
      mem[rf_if.rw] <= wtmp;
    end
  end
  assign rf_if.bus_a = f_dead ? DEAD : ((rf_if.ra == 5'd31 && !f_x31) ? 64'd0 : mem[rf_if.ra]);
  assign rf_if.bus_b = f_dead ? DEAD : ((rf_if.rb == 5'd31 && !f_x31) ? 64'd0 : mem[rf_if.rb]);

  typedef struct { logic [4:0] rw; logic [63:0] d; } wr_t;
  typedef struct { bit pass; int fc; int ff; int cyc; } res_t;
  wr_t  wq[$];
  res_t rq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: walk every read of both phases in issue order.
  task automatic model(output int fc, output int ff);
    logic [63:0] pat, exp_v, act_v;
    fc = 0;
    ff = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int r = 0; r < 32; r++) begin
        pat   = (ph == 1) ? ~64'(r) : 64'(r);
        exp_v = (r == 31) ? 64'd0 : pat;
        act_v = pat;
        if (f_stuck && r == f_sreg) act_v[f_sbit] = f_sval;
        if (r == 31 && !f_x31) act_v = 64'd0;
        if (f_dead) act_v = DEAD;
        if (act_v != exp_v) begin
          if (fc == 0) ff = r;
          fc++;
        end
      end
    end
  endtask

  task automatic push_run(input int t, input int nwr);
    wr_t w;
    res_t r;
    int fc, ff;
    for (int i = 0; i < nwr; i++) begin
      w.rw = 5'(i % 32);
      w.d  = (i >= 32) ? ~64'(i % 32) : 64'(i % 32);
      wq.push_back(w);
    end
    if (nwr == 64) begin
      model(fc, ff);
      r.pass = (fc == 0);
      r.fc   = fc;
      r.ff   = ff;
      r.cyc  = t + 98;
      rq.push_back(r);
    end
  endtask

  task automatic wait_results();
    int w = 0;
    while (rq.size() != 0 && w < 300) begin
      @(negedge clk_sys);
      w++;
    end
    if (w >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: %0d results still pending", rq.size());
    end
  endtask

  task automatic run_one(input bit dead, input bit x31, input bit st,
                         input int sreg, input int sbit, input bit sval);
    int t;
    f_dead = dead; f_x31 = x31; f_stuck = st;
    f_sreg = sreg; f_sbit = sbit; f_sval = sval;
    repeat ($urandom_range(1, 4)) @(negedge clk_sys);
    start = 1'b1;
    t = cyc + 1;
    push_run(t, 64);
    @(negedge clk_sys);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_results();
  endtask

  // write monitor
  always @(negedge clk_sys) begin
    if (rf_if.reg_wr === 1'b1) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: rw %0d data %h", rf_if.rw, rf_if.bus_w);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("write_addr", 64'(rf_if.rw), 64'(w.rw));
        chk("write_data", rf_if.bus_w, w.d);
      end
    end
  end

  // result monitor
  always @(negedge clk_sys) begin
    if (done === 1'b1) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: at cycle %0d", cyc);
      end else begin
        res_t r;
        r = rq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(r.cyc));
        chk("pass", 64'(pass), 64'(r.pass));
        chk("fail_count", 64'(fail_count), 64'(r.fc));
        chk("first_fail_addr", 64'(first_fail_addr), 64'(r.ff));
        chk("busy_in_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_reg_wr"}, 64'(rf_if.reg_wr), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_fail_count"}, 64'(fail_count), 64'd0);
    chk({tag, "_first_fail"}, 64'(first_fail_addr), 64'd0);
    chk({tag, "_ra"}, 64'(rf_if.ra), 64'd0);
    chk({tag, "_rb"}, 64'(rf_if.rb), 64'd0);
    chk({tag, "_rw"}, 64'(rf_if.rw), 64'd0);
    chk({tag, "_bus_w"}, rf_if.bus_w, 64'd0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_zero("reset");
    rst = 1'b0;

    run_one(0, 0, 0, 0, 0, 0);
    run_one(0, 0, 1, 5, 3, 0);
    run_one(0, 1, 0, 0, 0, 0);
    run_one(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      run_one(0, bit'($urandom_range(0, 1)), 1, $urandom_range(0, 31),
              $urandom_range(0, 63), bit'($urandom_range(0, 1)));

    // reset in the middle of a clean run
    f_dead = 0; f_x31 = 0; f_stuck = 0;
    repeat ($urandom_range(1, 4)) @(negedge clk_sys);
    start = 1'b1;
    t = cyc + 1;
    push_run(t, 32);
    @(negedge clk_sys);
    start = 1'b0;
    while (cyc < t + 40) @(negedge clk_sys);
    rst = 1'b1;
    #1;
    check_zero("midrun_reset");
    @(negedge clk_sys);
    rst = 1'b0;
    run_one(0, 0, 0, 0, 0, 0);

    // start held high: back-to-back runs 100 cycles apart
    repeat ($urandom_range(1, 4)) @(negedge clk_sys);
    start = 1'b1;
    t = cyc + 1;
    push_run(t, 64);
    push_run(t + 100, 64);
    while (cyc < t + 198) @(negedge clk_sys);
    start = 1'b0;
    wait_results();

    repeat (5) @(negedge clk_sys);
    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("results_drained", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
